// File: rtl/rbcp_reg_slave.sv
// rbcp_reg_slave: RBCP local-bus responder for the SiTCP register protocol.
// Decodes a window of 2*DEPTH bytes starting at BASE_ADDR: the lower DEPTH
// bytes are read/write control registers, the upper DEPTH bytes return the
// read-only STATUS_IN bytes. ACK is issued 1+ACK_DELAY cycles after a strobe.
// Optional build macro: RBCP_REG_SLAVE_STATUS_SYNC_EN adds a two-flop
// synchronizer on STATUS_IN ahead of read sampling.
module rbcp_reg_slave #(
    parameter logic [31:0]        BASE_ADDR = 32'h0000_0000,
    parameter int                 DEPTH     = 16,
    parameter int                 ACK_DELAY = 0,
    parameter logic [8*DEPTH-1:0] RST_VALUE = {DEPTH{8'h00}}
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 RBCP_ACT,
    input  logic [31:0]          RBCP_ADDR,
    input  logic                 RBCP_WE,
    input  logic [7:0]           RBCP_WD,
    input  logic                 RBCP_RE,
    output logic                 RBCP_ACK,
    output logic [7:0]           RBCP_RD,
    output logic [8*DEPTH-1:0]   REG_OUT,
    output logic [DEPTH-1:0]     WR_PULSE,
    input  logic [8*DEPTH-1:0]   STATUS_IN,
    output logic [7:0]           DROP_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [31:0] CTRL_LIM = 32'(DEPTH);
    localparam logic [31:0] WIN_LIM  = 32'(2 * DEPTH);
    localparam logic [3:0]  CNT_LOAD = (ACK_DELAY > 0) ? 4'(ACK_DELAY - 1) : 4'd0;

    state_t               state_r;
    logic [3:0]           cnt_r;
    logic                 ack_r;
    logic [7:0]           rd_r;
    logic [7:0]           hold_r;
    logic [8*DEPTH-1:0]   reg_r;
    logic [DEPTH-1:0]     wr_pulse_r;
    logic [7:0]           drop_r;

    logic [31:0]          off_s;
    logic                 hit_s;
    logic                 ctrl_s;
    logic                 strobe_s;
    logic                 accept_s;
    logic                 busy_s;
    logic [7:0]           rd_data_s;
    logic [8*DEPTH-1:0]   status_s;

`ifdef RBCP_REG_SLAVE_STATUS_SYNC_EN
    logic [8*DEPTH-1:0]   status_meta_r;
    logic [8*DEPTH-1:0]   status_sync_r;

    // Two-flop synchronizer bringing STATUS_IN into the CLK domain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            status_meta_r <= {(8*DEPTH){1'b0}};
            status_sync_r <= {(8*DEPTH){1'b0}};
        end else begin
            status_meta_r <= STATUS_IN;
            status_sync_r <= status_meta_r;
        end
    end

    assign status_s = status_sync_r;
`else
    assign status_s = STATUS_IN;
`endif

    // Address decode and read-data selection for the byte addressed this cycle.
    always_comb begin
        off_s     = RBCP_ADDR - BASE_ADDR;
        hit_s     = (off_s < WIN_LIM);
        ctrl_s    = (off_s < CTRL_LIM);
        strobe_s  = RBCP_WE | RBCP_RE;
        busy_s    = (state_r != ST_IDLE);
        accept_s  = (state_r == ST_IDLE) && strobe_s && hit_s;
        rd_data_s = 8'h00;
        if (RBCP_WE) begin
            // A write (including WE+RE together) returns zero read data.
            rd_data_s = 8'h00;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_data_s = rd_data_s | ((off_s == 32'(i)) ? reg_r[8*i +: 8] : 8'h00);
                rd_data_s = rd_data_s | ((off_s == 32'(DEPTH + i)) ? status_s[8*i +: 8] : 8'h00);
            end
        end
    end

    // Handshake FSM: accept in IDLE, optional delay in WAIT, one-cycle ACK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            ack_r   <= 1'b0;
            rd_r    <= 8'h00;
            hold_r  <= 8'h00;
        end else begin
            ack_r <= 1'b0;
            rd_r  <= 8'h00;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        hold_r <= rd_data_s;
                        if (ACK_DELAY == 0) begin
                            state_r <= ST_ACK;
                            ack_r   <= 1'b1;
                            rd_r    <= rd_data_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= CNT_LOAD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!RBCP_ACT) begin
                        // Master gave up: abandon silently.
                        state_r <= ST_IDLE;
                        cnt_r   <= 4'd0;
                    end else if (cnt_r == 4'd0) begin
                        state_r <= ST_ACK;
                        ack_r   <= 1'b1;
                        rd_r    <= hold_r;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

    // Control register bank and the per-byte write pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            reg_r      <= RST_VALUE;
            wr_pulse_r <= {DEPTH{1'b0}};
        end else begin
            wr_pulse_r <= {DEPTH{1'b0}};
            if (accept_s && RBCP_WE && ctrl_s) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (off_s == 32'(i)) begin
                        reg_r[8*i +: 8] <= RBCP_WD;
                        wr_pulse_r[i]   <= 1'b1;
                    end
                end
            end
        end
    end

    // Saturating count of in-window strobes that arrive while busy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_r <= 8'h00;
        end else if (busy_s && strobe_s && hit_s && (drop_r != 8'hFF)) begin
            drop_r <= drop_r + 8'd1;
        end else begin
            drop_r <= drop_r;
        end
    end

    assign RBCP_ACK = ack_r;
    assign RBCP_RD  = rd_r;
    assign REG_OUT  = reg_r;
    assign WR_PULSE = wr_pulse_r;
    assign DROP_CNT = drop_r;

endmodule

// File: tb/tb_rbcp_reg_slave.sv
// Testbench for rbcp_reg_slave: three instances (ACK_DELAY 0, 3, 5) share one
// stimulus stream; a timeline reference model predicts ACKs into a queue that
// a monitor drains, and tracks register, pulse and drop-count expectations.
module tb_rbcp_reg_slave;

    localparam logic [31:0]  BASE = 32'h8000_0100;
    localparam logic [127:0] RSTV = 128'h0F0E_0D0C_0B0A_0908_0706_0504_5A02_0100;
    localparam int DLY [3] = '{0, 3, 5};

    logic         clk = 1'b0;
    logic         rst;
    logic         act;
    logic [31:0]  addr;
    logic         we;
    logic [7:0]   wd;
    logic         re;
    logic [127:0] status;

    logic         ack  [3];
    logic [7:0]   rd   [3];
    logic [127:0] regq [3];
    logic [15:0]  wrp  [3];
    logic [7:0]   dcnt [3];

    typedef struct {
        int         inst;
        int         cyc;
        logic [7:0] rd;
    } exp_t;

    exp_t         expq[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    bit           mon_en = 1'b0;

    logic [127:0] mreg [3];
    logic [127:0] cur_reg [3];
    logic [15:0]  nxt_pulse [3];
    logic [15:0]  cur_pulse [3];
    int           drop [3];
    int           cur_drop [3];
    int           busy_until [3];
    int           acc_t [3];
    int           wait_hi [3];

    rbcp_reg_slave #(.BASE_ADDR(BASE), .DEPTH(16), .ACK_DELAY(0), .RST_VALUE(RSTV)) dut0 (
        .CLK(clk), .RST(rst), .RBCP_ACT(act), .RBCP_ADDR(addr), .RBCP_WE(we), .RBCP_WD(wd),
        .RBCP_RE(re), .RBCP_ACK(ack[0]), .RBCP_RD(rd[0]), .REG_OUT(regq[0]),
        .WR_PULSE(wrp[0]), .STATUS_IN(status), .DROP_CNT(dcnt[0]));
    rbcp_reg_slave #(.BASE_ADDR(BASE), .DEPTH(16), .ACK_DELAY(3), .RST_VALUE(RSTV)) dut3 (
        .CLK(clk), .RST(rst), .RBCP_ACT(act), .RBCP_ADDR(addr), .RBCP_WE(we), .RBCP_WD(wd),
        .RBCP_RE(re), .RBCP_ACK(ack[1]), .RBCP_RD(rd[1]), .REG_OUT(regq[1]),
        .WR_PULSE(wrp[1]), .STATUS_IN(status), .DROP_CNT(dcnt[1]));
    rbcp_reg_slave #(.BASE_ADDR(BASE), .DEPTH(16), .ACK_DELAY(5), .RST_VALUE(RSTV)) dut5 (
        .CLK(clk), .RST(rst), .RBCP_ACT(act), .RBCP_ADDR(addr), .RBCP_WE(we), .RBCP_WD(wd),
        .RBCP_RE(re), .RBCP_ACK(ack[2]), .RBCP_RD(rd[2]), .REG_OUT(regq[2]),
        .WR_PULSE(wrp[2]), .STATUS_IN(status), .DROP_CNT(dcnt[2]));

    always #5 clk = ~clk;

    // Cycle counter; model "next" state becomes the expected state of the new cycle.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int k = 0; k < 3; k++) begin
                cur_reg[k]   = mreg[k];
                cur_pulse[k] = nxt_pulse[k];
                cur_drop[k]  = drop[k];
            end
        end
    end

    // Remove instance k's pending ACK that has not yet come due by cycle n.
    task automatic cancel(input int k, input int n);
        for (int i = expq.size() - 1; i >= 0; i--)
            if (expq[i].inst == k && expq[i].cyc > n) expq.delete(i);
    endtask

    // Reference model: inputs held during cycle n are applied to every instance.
    task automatic model(input logic a, input logic w, input logic r, input logic [31:0] off,
                         input logic [7:0] d, input logic rs);
        int n;
        bit in_wait;
        logic [7:0] rdv;
        n = cyc;
        for (int k = 0; k < 3; k++) begin
            nxt_pulse[k] = 16'h0000;
            in_wait = (n >= acc_t[k] + 1) && (n <= wait_hi[k]);
            if (rs) begin
                cancel(k, n);
                mreg[k] = RSTV;
                drop[k] = 0;
                busy_until[k] = n;
                wait_hi[k] = -1;
            end else begin
                if ((w || r) && off < 32'd32) begin
                    if (n <= busy_until[k]) begin
                        if (drop[k] < 255) drop[k] = drop[k] + 1;
                    end else begin
                        if (w) rdv = 8'h00;
                        else if (off < 32'd16) rdv = mreg[k][off*32'd8 +: 8];
                        else rdv = status[(off - 32'd16)*32'd8 +: 8];
                        if (w && off < 32'd16) begin
                            mreg[k][off*32'd8 +: 8] = d;
                            nxt_pulse[k][off[3:0]] = 1'b1;
                        end
                        expq.push_back('{k, n + 1 + DLY[k], rdv});
                        acc_t[k] = n;
                        wait_hi[k] = n + DLY[k];
                        busy_until[k] = n + 1 + DLY[k];
                    end
                end
                if (in_wait && !a) begin
                    cancel(k, n);
                    busy_until[k] = n;
                    wait_hi[k] = -1;
                end
            end
        end
    endtask

    // Drive one cycle of bus inputs, update the model, advance past the edge.
    task automatic step(input logic a, input logic w, input logic r, input logic [31:0] off,
                        input logic [7:0] d, input logic rs);
        act = a; we = w; re = r; addr = BASE + off; wd = d; rst = rs;
        model(a, w, r, off, d, rs);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
    endtask

    // Monitor: compare this cycle's outputs of every instance with the model.
    task automatic check_cycle();
        int idx;
        bit want_ack;
        for (int k = 0; k < 3; k++) begin
            idx = -1;
            for (int i = 0; i < expq.size(); i++)
                if (idx < 0 && expq[i].inst == k) idx = i;
            want_ack = (idx >= 0) && (expq[idx].cyc <= cyc);
            checks++;
            if (ack[k] !== want_ack) begin
                errors++;
                $display("FAIL ack dut%0d cyc=%0d got=%b want=%b", k, cyc, ack[k], want_ack);
            end
            if (ack[k] === 1'b1 && idx >= 0) begin
                checks++;
                if (rd[k] !== expq[idx].rd) begin
                    errors++;
                    $display("FAIL rd_data dut%0d cyc=%0d got=%h want=%h", k, cyc, rd[k], expq[idx].rd);
                end
                expq.delete(idx);
            end else if (want_ack) begin
                expq.delete(idx);
            end
            if (ack[k] !== 1'b1) begin
                checks++;
                if (rd[k] !== 8'h00) begin
                    errors++;
                    $display("FAIL rd_idle dut%0d cyc=%0d got=%h want=00", k, cyc, rd[k]);
                end
            end
            checks++;
            if (regq[k] !== cur_reg[k]) begin
                errors++;
                $display("FAIL reg_out dut%0d cyc=%0d got=%h want=%h", k, cyc, regq[k], cur_reg[k]);
            end
            checks++;
            if (wrp[k] !== cur_pulse[k]) begin
                errors++;
                $display("FAIL wr_pulse dut%0d cyc=%0d got=%h want=%h", k, cyc, wrp[k], cur_pulse[k]);
            end
            checks++;
            if (int'(dcnt[k]) != cur_drop[k]) begin
                errors++;
                $display("FAIL drop_cnt dut%0d cyc=%0d got=%0d want=%0d", k, cyc, dcnt[k], cur_drop[k]);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) check_cycle();
        end
    end

    // Stimulus: directed scenarios, drop-counter saturation, then random traffic.
    initial begin
        logic        r_act, r_we, r_re, r_rst, strobe;
        logic [31:0] r_off;
        logic [7:0]  r_wd;
        for (int k = 0; k < 3; k++) begin
            mreg[k] = RSTV; cur_reg[k] = RSTV;
            nxt_pulse[k] = 16'h0000; cur_pulse[k] = 16'h0000;
            drop[k] = 0; cur_drop[k] = 0;
            busy_until[k] = -1; acc_t[k] = -10; wait_hi[k] = -1;
        end
        status = {$urandom, $urandom, $urandom, $urandom};
        status[15:8] = 8'h77;

        repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0, 8'h00, 1'b1);
        mon_en = 1'b1;
        idle(2);
        // reset value readback of byte 3
        step(1'b1, 1'b0, 1'b1, 32'd3, 8'h00, 1'b0); idle(8);
        // write then read control byte 2
        step(1'b1, 1'b1, 1'b0, 32'd2, 8'hC3, 1'b0); idle(8);
        step(1'b1, 1'b0, 1'b1, 32'd2, 8'h00, 1'b0); idle(8);
        // status byte 1: read, then write (ack only)
        step(1'b1, 1'b0, 1'b1, 32'd17, 8'h00, 1'b0); idle(8);
        step(1'b1, 1'b1, 1'b0, 32'd17, 8'h99, 1'b0); idle(8);
        // second read two cycles after the first
        step(1'b1, 1'b0, 1'b1, 32'd5, 8'h00, 1'b0);
        idle(1);
        step(1'b1, 1'b0, 1'b1, 32'd6, 8'h00, 1'b0); idle(8);
        // ACT dropped two cycles into a fresh access
        step(1'b1, 1'b0, 1'b1, 32'd4, 8'h00, 1'b0);
        idle(1);
        repeat (7) step(1'b0, 1'b0, 1'b0, 32'd0, 8'h00, 1'b0);
        idle(4);
        // misses: just past the window and just below the base
        step(1'b1, 1'b0, 1'b1, 32'd32, 8'h00, 1'b0); idle(20);
        step(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 8'hAA, 1'b0); idle(4);
        // WE and RE together
        step(1'b1, 1'b1, 1'b1, 32'd0, 8'h11, 1'b0); idle(8);
        // reset during the wait phase, then a normal access
        step(1'b1, 1'b1, 1'b0, 32'd7, 8'h3C, 1'b0);
        idle(1);
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'd0, 8'h00, 1'b1);
        idle(3);
        step(1'b1, 1'b0, 1'b1, 32'd7, 8'h00, 1'b0); idle(8);
        // continuous strobes drive the drop counters to saturation
        repeat (300) step(1'b1, 1'b0, 1'b1, 32'd1, 8'h00, 1'b0);
        idle(8);
        // randomized traffic including misses, aborts and resets
        repeat (1500) begin
            if ($urandom_range(0, 19) == 0) status = {$urandom, $urandom, $urandom, $urandom};
            r_act  = ($urandom_range(0, 19) != 0);
            strobe = ($urandom_range(0, 2) == 0);
            r_we   = strobe && ($urandom_range(0, 1) == 1);
            r_re   = strobe && (!r_we || ($urandom_range(0, 3) == 0));
            r_off  = 32'($urandom_range(0, 40));
            r_wd   = 8'($urandom);
            r_rst  = ($urandom_range(0, 99) == 0);
            step(r_act, r_we, r_re, r_off, r_wd, r_rst);
        end
        idle(20);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL leftover_acks got=%0d pending want=0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rbcp_reg_slave.md
# rbcp_reg_slave

RBCP responder that terminates the local-bus side of the SiTCP UDP register protocol. It decodes one address window and exposes it as a bank of byte-wide read/write control registers plus a bank of read-only status bytes. It returns acknowledge and read data back to the SiTCP core. It sits in the USRCLK domain next to the SiTCP wrapper and drives its RBCP_ACK and RBCP_RD inputs.

## Interface
- BASE_ADDR, 32'h0000_0000: first byte address of the window.
- DEPTH, 16: number of control registers and status bytes, range 1..128. The window spans 2*DEPTH bytes.
- ACK_DELAY, 0: extra wait cycles before ACK, range 0..15.
- RST_VALUE, {DEPTH{8'h00}}: flattened reset value. Byte i is [8i+7:8i].
- CLK  in  1  system clock (USRCLK domain, 125 MHz).
- RST  in  1  synchronous, active-high reset.
- RBCP_ACT  in  1  RBCP transaction active.
- RBCP_ADDR  in  32  byte address, valid with WE/RE.
- RBCP_WE  in  1  one-cycle write strobe.
- RBCP_WD  in  8  write data, valid with WE.
- RBCP_RE  in  1  one-cycle read strobe.
- RBCP_ACK  out  1  one-cycle acknowledge.
- RBCP_RD  out  8  read data. Valid in the ACK cycle, 0 otherwise.
- REG_OUT  out  8*DEPTH  control registers, flattened.
- WR_PULSE  out  DEPTH  one-cycle pulse per control byte written.
- STATUS_IN  in  8*DEPTH  status bytes, flattened.
- DROP_CNT  out  8  saturating count of dropped requests.

## Operation
- Offset: off = RBCP_ADDR - BASE_ADDR, computed as a 32-bit unsigned value.
  - Hit when off < 2*DEPTH.
  - Control byte when off < DEPTH; status byte when DEPTH <= off < 2*DEPTH.
- FSM states: IDLE, WAIT, ACK.
  - IDLE → WAIT when a strobe hits and ACK_DELAY > 0. Load the counter with ACK_DELAY-1.
  - IDLE → ACK when a strobe hits and ACK_DELAY = 0.
  - WAIT: decrement the counter; go to ACK when the counter is 0.
  - ACK: assert RBCP_ACK for one cycle, then return to IDLE.
- Write hit on a control byte (in IDLE):
  - REG_OUT byte off ← RBCP_WD at the strobe edge.
  - WR_PULSE[off] = 1 for the following cycle.
- Write hit on a status byte: acknowledged; no register changes and no WR_PULSE.
- Read hit: the data byte is latched at the strobe edge into an 8-bit holding register.
  - Source is the REG_OUT byte for a control offset, the STATUS_IN byte for a status offset.
  - RBCP_RD drives the holding register only while RBCP_ACK = 1.
- WE and RE in the same cycle: treated as a write; RBCP_RD = 0 in the ACK cycle.
- Miss (outside the window): no state change and no ACK, so another slave may answer.
- Strobe arriving while the FSM is in WAIT or ACK: dropped, and DROP_CNT increments, saturating at 8'hFF.
- RBCP_ACT low while in WAIT: abort to IDLE, no ACK. An already committed write stays in place.
- Reset values, held while RST = 1:
  - FSM = IDLE, counter = 0.
  - RBCP_ACK = 0, RBCP_RD = 0.
  - REG_OUT = RST_VALUE.
  - WR_PULSE = 0, DROP_CNT = 0.
  - The holding register = 0.
- RST asserted mid-transaction: the access is abandoned with no ACK.

## Timing
- Strobe in cycle T, with ACK_DELAY = d: RBCP_ACK is high in cycle T+1+d, for exactly one cycle.
- REG_OUT reflects the write from T+1. WR_PULSE is high in T+1 only.
- Read data is sampled in cycle T. A STATUS_IN change after T is not returned.
- All outputs are registered. There is no combinational path from the RBCP inputs to RBCP_ACK or RBCP_RD.
- Back-to-back throughput: one access per 2+d cycles. A strobe in the ACK cycle is dropped.

## Configuration
- RBCP_REG_SLAVE_STATUS_SYNC_EN:
  - Defined: STATUS_IN passes through a two-flop synchronizer (reset to 0) before read sampling. Status read latency rises by 2 cycles relative to STATUS_IN changes; ACK timing is unchanged.
  - Undefined: STATUS_IN is sampled directly and must already be in the CLK domain.

## Test plan
- Reset, with RST_VALUE byte 3 = 8'h5A, d = 0:
  - Read offset 3 at T → RBCP_ACK at T+1 with RBCP_RD = 8'h5A.
  - REG_OUT byte 3 = 8'h5A throughout.
- Write BASE_ADDR+2 with 8'hC3, d = 0:
  - ACK at T+1; WR_PULSE = 16'h0004 at T+1 only.
  - A subsequent read returns 8'hC3.
- STATUS_IN byte 1 = 8'h77, DEPTH = 16:
  - Read BASE_ADDR+17 → RD = 8'h77.
  - Write BASE_ADDR+17 → ACK, no WR_PULSE, REG_OUT unchanged.
- d = 3, read at T:
  - ACK exactly at T+4.
  - A second RE at T+2 → dropped, no extra ACK, DROP_CNT = 1.
  - RBCP_ACT dropped at T+2 on a fresh access → no ACK.
- Miss and simultaneous strobes:
  - Read BASE_ADDR+32 with DEPTH = 16 → no ACK for 20 cycles, outputs idle.
  - WE and RE together at offset 0 with WD = 8'h11 → one ACK, RD = 0, REG_OUT byte 0 = 8'h11.
- RST asserted during WAIT (d = 5):
  - No ACK; REG_OUT returns to RST_VALUE; DROP_CNT = 0.
  - The next access completes normally.
